// File: rtl/canonical_row_streamer_pkg.sv
// rtl/canonical_row_streamer_pkg.sv - shared types for the canonical-form row streamer
package canonical_pkg;

   typedef logic [1:0] pauli_t;

   localparam pauli_t PAULI_I = 2'd0;
   localparam pauli_t PAULI_Z = 2'd1;
   localparam pauli_t PAULI_X = 2'd2;
   localparam pauli_t PAULI_Y = 2'd3;

   // Cells 0..num_qubit-1 are X-block, the rest Z-block.
   localparam logic X_BLOCK = 1'b0;
   localparam logic Z_BLOCK = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FEED,
      ST_FLUSH,
      ST_DRAIN_CR,
      ST_SHIFT
   } state_t;

endpackage

// File: rtl/canonical_row_streamer_if.sv
// rtl/canonical_row_streamer_if.sv - row, chain and result bundle of the canonical row streamer
interface canonical_row_streamer_if
   import canonical_pkg::*;
#(
   parameter int num_qubit  = 4,
   parameter int max_vector = 2**num_qubit,
   parameter int rank_w     = $clog2(num_qubit+1)
);
   logic                        start;
   logic                        busy;
   logic                        done;
   logic [rank_w-1:0]           rank;

   logic                        in_valid;
   logic                        in_ready;
   pauli_t [num_qubit-1:0]      row_in_literal;
   logic [max_vector-1:0]       row_in_phase;

   logic                        chain_ld;
   logic                        chain_second_CR;
   logic                        chain_second_stage;
   pauli_t [num_qubit-1:0]      chain_literal_out;
   logic [max_vector-1:0]       chain_phase_out;
   logic                        chain_flag_out;
   pauli_t [num_qubit-1:0]      chain_literal_in;
   logic [max_vector-1:0]       chain_phase_in;
   logic                        chain_flag_in;

   logic                        out_valid;
   pauli_t [num_qubit-1:0]      out_literal;
   logic [max_vector-1:0]       out_phase;
   logic                        out_residual;

   modport master (
      output start, in_valid, row_in_literal, row_in_phase,
             chain_literal_in, chain_phase_in, chain_flag_in,
      input  busy, done, rank, in_ready,
             chain_ld, chain_second_CR, chain_second_stage,
             chain_literal_out, chain_phase_out, chain_flag_out,
             out_valid, out_literal, out_phase, out_residual
   );

   modport slave (
      input  start, in_valid, row_in_literal, row_in_phase,
             chain_literal_in, chain_phase_in, chain_flag_in,
      output busy, done, rank, in_ready,
             chain_ld, chain_second_CR, chain_second_stage,
             chain_literal_out, chain_phase_out, chain_flag_out,
             out_valid, out_literal, out_phase, out_residual
   );

endinterface

// File: rtl/canonical_row_streamer_out_capture.sv
// rtl/canonical_row_streamer_out_capture.sv - tail-row sampling, residual tagging, rank counter
// Rank counting is present only when CANONICAL_RANK_EN is defined.
module canonical_out_capture
   import canonical_pkg::*;
#(
   parameter int num_qubit  = 4,
   parameter int max_vector = 2**num_qubit,
   parameter int rank_w     = $clog2(num_qubit+1)
)(
   input  logic                   clk,
   input  logic                   rst_new,
   input  logic                   sample,
   input  logic                   residual,
   input  pauli_t [num_qubit-1:0] tail_literal,
   input  logic [max_vector-1:0]  tail_phase,
   output logic                   out_valid,
   output pauli_t [num_qubit-1:0] out_literal,
   output logic [max_vector-1:0]  out_phase,
   output logic                   out_residual,
   output logic [rank_w-1:0]      rank
`ifdef CANONICAL_RANK_EN
   ,
   input  logic                   rank_clear
`endif
);

   logic                   valid_q, valid_d;
   pauli_t [num_qubit-1:0] literal_q, literal_d;
   logic [max_vector-1:0]  phase_q, phase_d;
   logic                   residual_q, residual_d;

   always_comb begin
      valid_d    = sample;
      literal_d  = literal_q;
      phase_d    = phase_q;
      residual_d = residual_q;
      if (sample) begin
         literal_d  = tail_literal;
         phase_d    = tail_phase;
         residual_d = residual;
      end
   end

   always_ff @(posedge clk or posedge rst_new) begin
      if (rst_new) begin
         valid_q    <= 1'b0;
         literal_q  <= '0;
         phase_q    <= '0;
         residual_q <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         literal_q  <= literal_d;
         phase_q    <= phase_d;
         residual_q <= residual_d;
      end
   end

   assign out_valid    = valid_q;
   assign out_literal  = literal_q;
   assign out_phase    = phase_q;
   assign out_residual = residual_q;

`ifdef CANONICAL_RANK_EN
   logic [rank_w-1:0] rank_q, rank_d;

   always_comb begin
      rank_d = rank_q;
      if (rank_clear)
         rank_d = '0;
      else if (sample && !residual)
         rank_d = rank_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst_new) begin
      if (rst_new)
         rank_q <= '0;
      else
         rank_q <= rank_d;
   end

   assign rank = rank_q;
`else
   assign rank = '0;
`endif

endmodule

// File: rtl/canonical_row_streamer.sv
// rtl/canonical_row_streamer.sv - sequencer feeding, flushing and draining the canonical reduction chain
// Optional rank counter enabled by CANONICAL_RANK_EN.
module canonical_row_streamer
   import canonical_pkg::*;
#(
   parameter int num_qubit  = 4,
   parameter int max_vector = 2**num_qubit,
   parameter int num_cells  = 2*num_qubit
)(
   input  logic                   clk,
   input  logic                   rst_new,
   canonical_row_streamer_if.slave bus
);

   localparam int CNT_W  = $clog2(num_cells+1);
   localparam int RANK_W = $clog2(num_qubit+1);
   localparam logic [CNT_W-1:0] LAST_FEED = CNT_W'(num_qubit-1);
   localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(num_cells-1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             accept;
   logic             capture_residual;

   assign accept           = (state_q == ST_FEED) && bus.in_valid;
   assign capture_residual = (state_q == ST_FEED) || (state_q == ST_FLUSH);

   // Chain controls are combinational so a stalled FEED cycle keeps ld low on the same edge.
   always_comb begin
      state_d                = state_q;
      cnt_d                  = cnt_q;
      done_d                 = 1'b0;
      bus.in_ready           = (state_q == ST_FEED);
      bus.chain_ld           = 1'b0;
      bus.chain_second_CR    = 1'b0;
      bus.chain_second_stage = 1'b0;
      bus.chain_literal_out  = {num_qubit{PAULI_I}};
      bus.chain_phase_out    = '0;
      bus.chain_flag_out     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_FEED;
               cnt_d   = '0;
            end
         end
         ST_FEED: begin
            bus.chain_ld = accept;
            if (accept) begin
               bus.chain_literal_out = bus.row_in_literal;
               bus.chain_phase_out   = bus.row_in_phase;
               bus.chain_flag_out    = 1'b1;
               cnt_d                 = cnt_q + 1'b1;
               if (cnt_q == LAST_FEED) begin
                  state_d = ST_FLUSH;
                  cnt_d   = '0;
               end
            end
         end
         ST_FLUSH: begin
            bus.chain_ld = 1'b1;
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == LAST_CELL) begin
               state_d = ST_DRAIN_CR;
               cnt_d   = '0;
            end
         end
         ST_DRAIN_CR: begin
            bus.chain_ld        = 1'b1;
            bus.chain_second_CR = 1'b1;
            state_d             = ST_SHIFT;
            cnt_d               = '0;
         end
         ST_SHIFT: begin
            bus.chain_ld           = 1'b1;
            bus.chain_second_stage = 1'b1;
            cnt_d                  = cnt_q + 1'b1;
            if (cnt_q == LAST_CELL) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst_new) begin
      if (rst_new) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;

`ifdef CANONICAL_RANK_EN
   logic start_accept;
   assign start_accept = (state_q == ST_IDLE) && bus.start;
`endif

   canonical_out_capture #(
      .num_qubit  (num_qubit),
      .max_vector (max_vector),
      .rank_w     (RANK_W)
   ) u_capture (
      .clk          (clk),
      .rst_new      (rst_new),
      .sample       (bus.chain_ld && bus.chain_flag_in),
      .residual     (capture_residual),
      .tail_literal (bus.chain_literal_in),
      .tail_phase   (bus.chain_phase_in),
      .out_valid    (bus.out_valid),
      .out_literal  (bus.out_literal),
      .out_phase    (bus.out_phase),
      .out_residual (bus.out_residual),
      .rank         (bus.rank)
`ifdef CANONICAL_RANK_EN
      ,
      .rank_clear   (start_accept)
`endif
   );

endmodule

// File: doc/canonical_row_streamer.md
Name: canonical_row_streamer

Overview:
Sequencer and row source/sink for the canonical-form reduction chain: a cascade of num_qubit X-block cells followed by num_qubit Z-block cells.
- Accepts stabilizer rows on a valid/ready stream and shifts them into the head of the chain.
- Flushes the chain, then commands the storage-register drain (second_CR) and the pass-through shift (second_stage).
- Collects rows emerging from the chain tail, returning them tagged canonical or residual.
- Owns every shared chain control: ld_trans, ld_store, second_CR, second_stage.

Parameters:
num_qubit, 4, qubits per row; literals per row
max_vector, 2**num_qubit, phase-vector bits per row
num_cells, 2*num_qubit, cells in the chain (X-block then Z-block)

Ports:
clk  in  1  clock
rst_new  in  1  reset
start  in  1  begin one tableau; sampled in IDLE only
in_valid  in  1  row_in_* valid
in_ready  out  1  streamer accepts a row this cycle
row_in_literal  in  [1:0] x num_qubit  Pauli literals (I=0,Z=1,X=2,Y=3)
row_in_phase  in  1 x max_vector  phase vector
chain_ld  out  1  drives ld_trans and ld_store of all cells (tied together)
chain_second_CR  out  1  drain storage registers into transition path
chain_second_stage  out  1  pass-through shift, storing disabled
chain_literal_out  out  [1:0] x num_qubit  row into cell 0
chain_phase_out  out  1 x max_vector  phase into cell 0
chain_flag_out  out  1  flag into cell 0 (1 = real row)
chain_literal_in  in  [1:0] x num_qubit  tail row from last cell
chain_phase_in  in  1 x max_vector  tail phase
chain_flag_in  in  1  tail flag
out_valid  out  1  out_* holds a row (one-cycle pulse per row)
out_literal  out  [1:0] x num_qubit  collected row literals
out_phase  out  1 x max_vector  collected row phase
out_residual  out  1  1 = row left chain before drain (dependent/unreduced)
busy  out  1  tableau in progress
done  out  1  one-cycle pulse on completion
rank  out  $clog2(num_qubit+1)  canonical-row count (optional feature)

Behaviour:
- Reset: rst_new is asynchronous, active-high; clock is clk. Reset drives state IDLE, all counters 0, and every output 0: in_ready, chain_*, out_*, busy, done, rank. rst_new also resets the chain cells. Reset mid-operation abandons the tableau; no done is produced.
- FSM states: IDLE, FEED, FLUSH, DRAIN_CR, SHIFT.
- IDLE: start=1 → FEED, busy=1 from the next cycle. start outside IDLE is ignored.
- FEED:
  - in_ready=1 (combinational from state).
  - Accept (in_valid&in_ready): chain_ld=1; chain_literal/phase_out = row_in_*; chain_flag_out=1; feed_cnt++.
  - in_valid=0: chain_ld=0 and zero row driven. This is a true stall: ld_trans and ld_store must never differ.
  - Accept with feed_cnt==num_qubit-1 → FLUSH.
- FLUSH: chain_ld=1, zero row with flag 0, for exactly num_cells cycles → DRAIN_CR.
- DRAIN_CR: one cycle, chain_second_CR=1, chain_ld=1, zero row → SHIFT.
- SHIFT: chain_second_stage=1, chain_ld=1, zero row, for exactly num_cells cycles. The final cycle → IDLE, with busy=0 and done=1 registered in the following cycle.
- Capture: at every clk edge with chain_ld=1 and chain_flag_in=1, register the tail row into out_*; out_valid=1 for the next cycle.
  - out_residual=1 if captured in FEED/FLUSH, 0 if captured in DRAIN_CR/SHIFT.
  - Latency is one cycle from tail to out_*. No output backpressure.
- Canonical rows appear in chain order: the row stored in the last cell first.
- Stall-free timing: busy is high for num_qubit+2*num_cells+1 cycles (21 at defaults).
- Counters are sized $clog2(num_cells+1) and saturate-free by construction.

Optional Feature:
CANONICAL_RANK_EN
- Defined: rank clears on the start-accept edge and increments on each capture with out_residual=0. It is valid once done pulses and holds until the next start.
- Undefined: rank is tied to 0 and the counter logic is omitted.

Decomposition:
- Package canonical_pkg: pauli_t [1:0] with literal encodings PAULI_I/Z/X/Y, the FSM state enum, and the block_type constants X_BLOCK=0 and Z_BLOCK=1.
- Sub-module canonical_out_capture: the tail-sampling register, out_residual tagging, and the rank counter.
- FSM and cycle counters stay in the top level.

Test Plan:
1. Defaults; feed ZIII, IZII, IIZI, IIIZ, all phase 0, in_valid continuous → 4 out_valid pulses, all out_residual=0, rank=4; busy high 21 cycles; done one pulse.
2. Feed XIII, XIII, ZIII, IZII → exactly one residual row IIII with flag 1 during FLUSH; 3 canonical rows; rank=3.
3. Same as 1 with in_valid low 2 cycles after row 2 → chain_ld=0 and ld_trans==ld_store in those cycles; output identical to 1; busy high 23 cycles.
4. Assert rst_new during SHIFT → next cycle all outputs 0, state IDLE, no done; a fresh start then reproduces 1.
5. start asserted while busy → ignored; row count and done timing unchanged.
6. Phase check: feed XIII with phase[0]=1 and YIII with phase 0 → residual row ZIII, phase per row-multiplication rule.
